bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter P_DIGITS, default 2, number of BCD digits (1..6).
REQ-002 SHALL have parameter P_DEBOUNCE, default 2**16, number of consecutive stable clocks required to accept a button level.
REQ-003 SHALL have parameter P_SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 SHALL have port CLK  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port BTN_N  input  1  raw asynchronous push button, active-low (0 = pressed).
REQ-007 SHALL have port UP  input  1  count direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port CLR  input  1  synchronous clear-to-zero request.
REQ-009 SHALL have port LOAD  input  1  synchronous load request.
REQ-010 SHALL have port LOAD_VAL  input  4*P_DIGITS  BCD value for LOAD, digit 0 in bits [3:0].
REQ-011 SHALL have port BCD  output  4*P_DIGITS  current count, digit 0 in bits [3:0].
REQ-012 SHALL have port SEG  output  8*P_DIGITS  7-segment pattern per digit, active-low, bit 7 = DP, digit 0 in bits [7:0].
REQ-013 SHALL have port WRAP  output  1  one-cycle pulse on overflow/underflow (wrap mode) or blocked step at a limit (saturate mode).

Function
REQ-014 SHALL pass BTN_N through a two-flop synchroniser before any other use.
REQ-015 SHALL update the debounced button level only after the synchronised input differs from it for P_DEBOUNCE consecutive clocks; any return to the current debounced level restarts the count.
REQ-016 SHALL generate exactly one step pulse, one clock wide, on each debounced release (debounced level 0 -> 1); holding the button produces no further steps.
REQ-017 SHALL apply priority CLR > LOAD > step when several are asserted in the same cycle; lower-priority requests in that cycle are discarded.
REQ-018 SHALL set BCD to all zeros one clock after CLR is sampled high.
REQ-019 SHALL set BCD to LOAD_VAL one clock after LOAD is sampled high, replacing any LOAD_VAL digit greater than 9 with 9.
REQ-020 SHALL, on a step with UP=1, increment the value as a decimal number: digit 9 becomes 0 and carries into the next digit.
REQ-021 SHALL, on a step with UP=0, decrement as a decimal number: digit 0 becomes 9 and borrows from the next digit.
REQ-022 SHALL, in wrap mode, take all-9s + 1 to all-0s and all-0s - 1 to all-9s, asserting WRAP for the same cycle the new BCD value appears.
REQ-023 SHALL, in saturate mode, leave BCD unchanged on a step that would pass all-9s (up) or all-0s (down), asserting WRAP for one cycle.
REQ-024 SHALL sample UP on the cycle the step pulse occurs; UP changes at other times have no effect.
REQ-025 SHALL register SEG one clock after BCD, encoding 0..9 as C0,F9,A4,B0,99,92,82,F8,80,90 (hex), DP bit always 1.
REQ-026 SHALL give latency from debounced release to BCD update of one clock, and to SEG update of two clocks.

Reset
REQ-027 SHALL, while RST_N is low on a rising CLK, clear BCD to 0, SEG to C0 per digit, WRAP to 0, synchroniser flops and debounced level to 1 (released), and debounce counter to 0.
REQ-028 SHALL discard any in-progress debounce or pending step when reset is asserted mid-press; a release occurring after reset deasserts and preceded by a debounced press counts normally.
REQ-029 SHALL ignore CLR, LOAD and steps in any cycle RST_N is low.

Structure
REQ-030 SHALL place the BCD digit type, the 10-entry segment table and a digit-to-segment function in a shared package bcd_pkg.
REQ-031 SHALL implement the synchroniser and debouncer as one sub-module btn_debounce parameterised by P_DEBOUNCE, emitting the release pulse.
REQ-032 SHALL implement the digit chain with a generate loop over P_DIGITS, with no per-digit hand-written code.

Verification
REQ-033 Bench SHALL check reset: after RST_N low for 10 clocks -> BCD=0, SEG=C0 per digit, WRAP=0.
REQ-034 Bench SHALL press/release BTN_N nine times, each level held 2*P_DEBOUNCE clocks, UP=1 -> BCD steps 1..9; tenth release -> BCD=0x10, SEG digit1=F9, digit0=C0.
REQ-035 Bench SHALL apply a glitch train (BTN_N low for P_DEBOUNCE-1 clocks, repeated 5 times) -> BCD unchanged.
REQ-036 Bench SHALL load 0x99 with P_SATURATE=0 and step up -> BCD=0x00 with WRAP high exactly one cycle; then step down -> BCD=0x99, WRAP pulse.
REQ-037 Bench SHALL, with P_SATURATE=1, load 0x00 and step down -> BCD=0x00, WRAP pulse; load 0x9A -> BCD=0x99.
REQ-038 Bench SHALL assert CLR, LOAD (0x42) and a step in the same cycle -> BCD=0x00; then LOAD alone with a step -> BCD=0x42.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions for the up/down counter: the digit type, the
// 7-segment lookup table (active-low, DP bit 7 held off) and helper
// functions for segment encoding and LOAD value clamping.
// No ports (package).
// ---------------------------------------------------------------------------
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX   = 4'd9;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low segment patterns for 0..9; bit 7 (DP) is always 1 (off).
   localparam logic [7:0] SEG_TABLE [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   // Non-BCD codes blank the display rather than indexing past the table.
   function automatic logic [7:0] bcdToSeg(input bcd_digit_t d);
      logic [7:0] seg;
      seg = SEG_BLANK;
      if (d <= BCD_MAX) begin
         seg = SEG_TABLE[d];
      end
      return seg;
   endfunction

   // Loaded digits above 9 are forced to 9 so the count stays valid BCD.
   function automatic bcd_digit_t bcdClamp(input bcd_digit_t d);
      bcd_digit_t res;
      res = d;
      if (d > BCD_MAX) begin
         res = BCD_MAX;
      end
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser plus level debouncer for an active-low push button.
// Emits a one-clock pulse the cycle after the debounced level goes from
// pressed (0) to released (1).
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_btn_n    raw asynchronous button, 0 = pressed
//   o_release  one-clock pulse on each debounced release
// ---------------------------------------------------------------------------
module btn_debounce #(
   parameter int P_DEBOUNCE = 2**16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_n,
   output logic o_release
);

   localparam int CW = $clog2(P_DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(P_DEBOUNCE - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_release;
   logic [CW-1:0] r_cnt;

   logic w_differs;
   logic w_accept;

   // The new level is accepted on the P_DEBOUNCE-th consecutive clock that
   // the synchronised input disagrees with the current debounced level.
   assign w_differs = (r_sync2 != r_level);
   assign w_accept  = w_differs && (r_cnt == CNT_LAST);

   // Synchroniser, stability counter and debounced level. Any cycle where
   // the input agrees with the debounced level restarts the count, so short
   // glitches never reach the level. Reset returns everything to "released"
   // and drops any half-finished debounce or pending pulse.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_level   <= 1'b1;
         r_release <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn_n;
         r_sync2   <= r_sync1;
         r_release <= w_accept && r_sync2;
         if (w_accept) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else if (w_differs) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_release = r_release;

endmodule

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
// Multi-digit BCD up/down counter stepped by a debounced push button, with
// synchronous clear and load, wrap or saturate at the limits, and registered
// active-low 7-segment outputs.
// Ports:
//   CLK       system clock, rising edge
//   RST_N     synchronous active-low reset
//   BTN_N     raw push button, 0 = pressed; each release is one step
//   UP        direction sampled on the step: 1 = up, 0 = down
//   CLR       clear count to zero (highest priority)
//   LOAD      load LOAD_VAL (digits > 9 become 9)
//   LOAD_VAL  BCD load value, digit 0 in [3:0]
//   BCD       current count, digit 0 in [3:0]
//   SEG       7-segment patterns, one clock behind BCD, digit 0 in [7:0]
//   WRAP      one-cycle pulse on wrap, or on a step blocked at a limit
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
   parameter int P_DIGITS   = 2,
   parameter int P_DEBOUNCE = 2**16,
   parameter int P_SATURATE = 0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  BTN_N,
   input  logic                  UP,
   input  logic                  CLR,
   input  logic                  LOAD,
   input  logic [4*P_DIGITS-1:0] LOAD_VAL,
   output logic [4*P_DIGITS-1:0] BCD,
   output logic [8*P_DIGITS-1:0] SEG,
   output logic                  WRAP
);

   import bcd_pkg::*;

   logic [4*P_DIGITS-1:0] r_bcd;
   logic [8*P_DIGITS-1:0] r_seg;
   logic                  r_wrap;

   logic                  w_step;
   logic [P_DIGITS:0]     w_carry;
   logic [4*P_DIGITS-1:0] w_bcdNext;
   logic [4*P_DIGITS-1:0] w_loadVal;
   logic [8*P_DIGITS-1:0] w_segNext;
   logic                  w_overflow;
   logic                  w_block;

   btn_debounce #(
      .P_DEBOUNCE (P_DEBOUNCE)
   ) u_debounce (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_btn_n   (BTN_N),
      .o_release (w_step)
   );

   // w_carry[i] means digit i moves on this step: every lower digit is at
   // its rollover value (9 counting up, 0 counting down). A carry out of the
   // top digit is the overflow/underflow of the whole count.
   assign w_carry[0] = 1'b1;

   for (genvar gi = 0; gi < P_DIGITS; gi++) begin : g_digit
      bcd_digit_t w_digit;
      bcd_digit_t w_inc;
      bcd_digit_t w_dec;

      assign w_digit = r_bcd[4*gi +: 4];
      assign w_inc   = (w_digit == BCD_MAX) ? 4'd0 : w_digit + 4'd1;
      assign w_dec   = (w_digit == 4'd0) ? BCD_MAX : w_digit - 4'd1;

      assign w_carry[gi+1] = w_carry[gi] &
                             (UP ? (w_digit == BCD_MAX) : (w_digit == 4'd0));
      assign w_bcdNext[4*gi +: 4] = !w_carry[gi] ? w_digit : (UP ? w_inc : w_dec);
      assign w_loadVal[4*gi +: 4] = bcdClamp(LOAD_VAL[4*gi +: 4]);
      assign w_segNext[8*gi +: 8] = bcdToSeg(w_digit);
   end

   assign w_overflow = w_carry[P_DIGITS];
   assign w_block    = w_overflow && (P_SATURATE != 0);

   // Count register with CLR > LOAD > step priority. WRAP is registered on
   // the same edge as the new count so both appear together; in saturate
   // mode a blocked step leaves the count alone but still pulses WRAP.
   // SEG re-encodes the registered count, so it trails BCD by one clock.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_bcd  <= '0;
         r_seg  <= {P_DIGITS{bcdToSeg(4'd0)}};
         r_wrap <= 1'b0;
      end else begin
         r_seg  <= w_segNext;
         r_wrap <= 1'b0;
         if (CLR) begin
            r_bcd <= '0;
         end else if (LOAD) begin
            r_bcd <= w_loadVal;
         end else if (w_step) begin
            r_wrap <= w_overflow;
            if (!w_block) begin
               r_bcd <= w_bcdNext;
            end
         end
      end
   end

   assign BCD  = r_bcd;
   assign SEG  = r_seg;
   assign WRAP = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
// Directed bench driving a wrapping and a saturating counter with the same
// stimulus. Short debounce window keeps the run small.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

   localparam int P_DEB = 4;
   localparam int HOLD  = 2 * P_DEB;

   logic        clk;
   logic        rstN;
   logic        btnN;
   logic        up;
   logic        clr;
   logic        load;
   logic [7:0]  loadVal;
   logic [7:0]  bcd0;
   logic [7:0]  bcd1;
   logic [15:0] seg0;
   logic [15:0] seg1;
   logic        wrap0;
   logic        wrap1;

   int vecCnt  = 0;
   int missCnt = 0;
   int wrapCnt0;
   int wrapCnt1;
   logic [7:0] bcdAtWrap0;
   logic [7:0] bcdAtWrap1;

   logic [7:0] segTab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   bcd_updown_counter #(.P_DIGITS(2), .P_DEBOUNCE(P_DEB), .P_SATURATE(0)) u_dutWrap (
      .CLK(clk), .RST_N(rstN), .BTN_N(btnN), .UP(up), .CLR(clr), .LOAD(load),
      .LOAD_VAL(loadVal), .BCD(bcd0), .SEG(seg0), .WRAP(wrap0)
   );

   bcd_updown_counter #(.P_DIGITS(2), .P_DEBOUNCE(P_DEB), .P_SATURATE(1)) u_dutSat (
      .CLK(clk), .RST_N(rstN), .BTN_N(btnN), .UP(up), .CLR(clr), .LOAD(load),
      .LOAD_VAL(loadVal), .BCD(bcd1), .SEG(seg1), .WRAP(wrap1)
   );

   // 100 MHz bench clock; inputs change and outputs are sampled on negedges.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hold the button at one level for n clocks, tallying WRAP pulses.
   task automatic holdLevel(input logic level, input int n);
      for (int i = 0; i < n; i++) begin
         btnN = level;
         @(negedge clk);
         if (wrap0) begin wrapCnt0++; bcdAtWrap0 = bcd0; end
         if (wrap1) begin wrapCnt1++; bcdAtWrap1 = bcd1; end
      end
   endtask

   task automatic pressRelease();
      wrapCnt0 = 0;
      wrapCnt1 = 0;
      holdLevel(1'b0, HOLD);
      holdLevel(1'b1, HOLD);
   endtask

   task automatic doLoad(input logic [7:0] val);
      loadVal = val;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (10) @(negedge clk);
      vecCnt++; if (bcd0 !== 8'h00) begin missCnt++; $display("FAIL reset_bcd_wrap got %h want %h", bcd0, 8'h00); end
      vecCnt++; if (seg0 !== 16'hC0C0) begin missCnt++; $display("FAIL reset_seg_wrap got %h want %h", seg0, 16'hC0C0); end
      vecCnt++; if (wrap0 !== 1'b0) begin missCnt++; $display("FAIL reset_wrap_wrap got %b want 0", wrap0); end
      vecCnt++; if (bcd1 !== 8'h00) begin missCnt++; $display("FAIL reset_bcd_sat got %h want %h", bcd1, 8'h00); end
      vecCnt++; if (seg1 !== 16'hC0C0) begin missCnt++; $display("FAIL reset_seg_sat got %h want %h", seg1, 16'hC0C0); end
      vecCnt++; if (wrap1 !== 1'b0) begin missCnt++; $display("FAIL reset_wrap_sat got %b want 0", wrap1); end
      rstN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_count_up();
      logic [7:0] expBcd;
      up = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         pressRelease();
         expBcd = 8'(k);
         vecCnt++; if (bcd0 !== expBcd) begin missCnt++; $display("FAIL count_bcd step %0d got %h want %h", k, bcd0, expBcd); end
         vecCnt++; if (seg0 !== {8'hC0, segTab[k]}) begin missCnt++; $display("FAIL count_seg step %0d got %h want %h", k, seg0, {8'hC0, segTab[k]}); end
      end
      pressRelease();
      vecCnt++; if (bcd0 !== 8'h10) begin missCnt++; $display("FAIL count_carry_bcd got %h want %h", bcd0, 8'h10); end
      vecCnt++; if (seg0 !== 16'hF9C0) begin missCnt++; $display("FAIL count_carry_seg got %h want %h", seg0, 16'hF9C0); end
      vecCnt++; if (wrapCnt0 !== 0) begin missCnt++; $display("FAIL count_carry_wrap got %0d want 0", wrapCnt0); end
      vecCnt++; if (bcd1 !== 8'h10) begin missCnt++; $display("FAIL count_carry_bcd_sat got %h want %h", bcd1, 8'h10); end
   endtask

   task automatic test_glitch();
      wrapCnt0 = 0;
      wrapCnt1 = 0;
      for (int g = 0; g < 5; g++) begin
         holdLevel(1'b0, P_DEB - 1);
         holdLevel(1'b1, 4);
      end
      holdLevel(1'b1, HOLD);
      vecCnt++; if (bcd0 !== 8'h10) begin missCnt++; $display("FAIL glitch_bcd got %h want %h", bcd0, 8'h10); end
      vecCnt++; if (bcd1 !== 8'h10) begin missCnt++; $display("FAIL glitch_bcd_sat got %h want %h", bcd1, 8'h10); end
      vecCnt++; if (wrapCnt0 !== 0) begin missCnt++; $display("FAIL glitch_wrap got %0d want 0", wrapCnt0); end
   endtask

   task automatic test_wrap();
      doLoad(8'h99);
      vecCnt++; if (bcd0 !== 8'h99) begin missCnt++; $display("FAIL wrap_load got %h want %h", bcd0, 8'h99); end
      up = 1'b1;
      pressRelease();
      vecCnt++; if (bcd0 !== 8'h00) begin missCnt++; $display("FAIL wrap_up_bcd got %h want %h", bcd0, 8'h00); end
      vecCnt++; if (wrapCnt0 !== 1) begin missCnt++; $display("FAIL wrap_up_pulses got %0d want 1", wrapCnt0); end
      vecCnt++; if (bcdAtWrap0 !== 8'h00) begin missCnt++; $display("FAIL wrap_up_align got %h want %h", bcdAtWrap0, 8'h00); end
      vecCnt++; if (seg0 !== 16'hC0C0) begin missCnt++; $display("FAIL wrap_up_seg got %h want %h", seg0, 16'hC0C0); end
      vecCnt++; if (bcd1 !== 8'h99) begin missCnt++; $display("FAIL sat_up_bcd got %h want %h", bcd1, 8'h99); end
      vecCnt++; if (wrapCnt1 !== 1) begin missCnt++; $display("FAIL sat_up_pulses got %0d want 1", wrapCnt1); end
      up = 1'b0;
      pressRelease();
      vecCnt++; if (bcd0 !== 8'h99) begin missCnt++; $display("FAIL wrap_down_bcd got %h want %h", bcd0, 8'h99); end
      vecCnt++; if (wrapCnt0 !== 1) begin missCnt++; $display("FAIL wrap_down_pulses got %0d want 1", wrapCnt0); end
      vecCnt++; if (bcdAtWrap0 !== 8'h99) begin missCnt++; $display("FAIL wrap_down_align got %h want %h", bcdAtWrap0, 8'h99); end
      vecCnt++; if (bcd1 !== 8'h98) begin missCnt++; $display("FAIL sat_down_bcd got %h want %h", bcd1, 8'h98); end
      vecCnt++; if (wrapCnt1 !== 0) begin missCnt++; $display("FAIL sat_down_pulses got %0d want 0", wrapCnt1); end
   endtask

   task automatic test_saturate();
      doLoad(8'h00);
      up = 1'b0;
      pressRelease();
      vecCnt++; if (bcd1 !== 8'h00) begin missCnt++; $display("FAIL sat_floor_bcd got %h want %h", bcd1, 8'h00); end
      vecCnt++; if (wrapCnt1 !== 1) begin missCnt++; $display("FAIL sat_floor_pulses got %0d want 1", wrapCnt1); end
      vecCnt++; if (bcd0 !== 8'h99) begin missCnt++; $display("FAIL wrap_floor_bcd got %h want %h", bcd0, 8'h99); end
      doLoad(8'h9A);
      vecCnt++; if (bcd1 !== 8'h99) begin missCnt++; $display("FAIL sat_clamp_bcd got %h want %h", bcd1, 8'h99); end
      vecCnt++; if (bcd0 !== 8'h99) begin missCnt++; $display("FAIL wrap_clamp_bcd got %h want %h", bcd0, 8'h99); end
      vecCnt++; if (seg1 !== 16'h9090) begin missCnt++; $display("FAIL sat_clamp_seg got %h want %h", seg1, 16'h9090); end
   endtask

   task automatic test_priority();
      up      = 1'b1;
      clr     = 1'b1;
      load    = 1'b1;
      loadVal = 8'h42;
      pressRelease();
      clr  = 1'b0;
      load = 1'b0;
      holdLevel(1'b1, 2);
      vecCnt++; if (bcd0 !== 8'h00) begin missCnt++; $display("FAIL prio_clr_bcd got %h want %h", bcd0, 8'h00); end
      vecCnt++; if (bcd1 !== 8'h00) begin missCnt++; $display("FAIL prio_clr_bcd_sat got %h want %h", bcd1, 8'h00); end
      load = 1'b1;
      pressRelease();
      load = 1'b0;
      holdLevel(1'b1, 2);
      vecCnt++; if (bcd0 !== 8'h42) begin missCnt++; $display("FAIL prio_load_bcd got %h want %h", bcd0, 8'h42); end
      vecCnt++; if (seg0 !== 16'h99A4) begin missCnt++; $display("FAIL prio_load_seg got %h want %h", seg0, 16'h99A4); end
      vecCnt++; if (bcd1 !== 8'h42) begin missCnt++; $display("FAIL prio_load_bcd_sat got %h want %h", bcd1, 8'h42); end
   endtask

   task automatic test_borrow();
      doLoad(8'h40);
      up = 1'b0;
      pressRelease();
      vecCnt++; if (bcd0 !== 8'h39) begin missCnt++; $display("FAIL borrow_bcd got %h want %h", bcd0, 8'h39); end
      vecCnt++; if (seg0 !== 16'hB090) begin missCnt++; $display("FAIL borrow_seg got %h want %h", seg0, 16'hB090); end
      vecCnt++; if (wrapCnt0 !== 0) begin missCnt++; $display("FAIL borrow_wrap got %0d want 0", wrapCnt0); end
   endtask

   task automatic test_reset_midpress();
      up = 1'b1;
      wrapCnt0 = 0;
      holdLevel(1'b0, HOLD);
      rstN = 1'b0;
      holdLevel(1'b0, 2);
      rstN = 1'b1;
      holdLevel(1'b0, 2);
      holdLevel(1'b1, HOLD);
      vecCnt++; if (bcd0 !== 8'h00) begin missCnt++; $display("FAIL midpress_bcd got %h want %h", bcd0, 8'h00); end
      vecCnt++; if (wrapCnt0 !== 0) begin missCnt++; $display("FAIL midpress_wrap got %0d want 0", wrapCnt0); end
      pressRelease();
      vecCnt++; if (bcd0 !== 8'h01) begin missCnt++; $display("FAIL after_reset_step got %h want %h", bcd0, 8'h01); end
      vecCnt++; if (bcd1 !== 8'h01) begin missCnt++; $display("FAIL after_reset_step_sat got %h want %h", bcd1, 8'h01); end
   endtask

   initial begin
      rstN    = 1'b0;
      btnN    = 1'b1;
      up      = 1'b1;
      clr     = 1'b0;
      load    = 1'b0;
      loadVal = 8'h00;
      wrapCnt0 = 0;
      wrapCnt1 = 0;
      bcdAtWrap0 = 8'h00;
      bcdAtWrap1 = 8'h00;
      test_reset();
      test_count_up();
      test_glitch();
      test_wrap();
      test_saturate();
      test_priority();
      test_borrow();
      test_reset_midpress();
      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
      $finish;
   end

endmodule
